// File: rtl/fetch_pkg.sv
// Shared definitions for the PC register / instruction-fetch sequencer.
package fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HAVE  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch.sv
// Architectural PC plus fetch sequencer: requests the word at pc, holds it for
// the next-PC logic, and loads next_pc when downstream accepts.
module pc_fetch
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = FETCH_RESET_PC,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              imem_err,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  input  logic              issue_ready,
  input  logic [WORD_W-1:0] next_pc,
  output logic [CNT_W-1:0]  retired,
  output logic              fault
);

  fetch_state_t state, state_nxt;
  logic         capture;
  logic         accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs depend on state only, so no input reaches them combinationally.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    capture     = 1'b0;
    accept      = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          capture   = !imem_err;
          state_nxt = imem_err ? ST_FAULT : ST_HAVE;
        end
      end
      ST_HAVE: begin
        instr_valid = 1'b1;
        accept      = issue_ready;
        if (issue_ready) state_nxt = ST_FETCH;
      end
      ST_FAULT: fault = 1'b1;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      instr   <= '0;
      retired <= '0;
    end else begin
      if (capture) instr <= imem_rdata;
      if (accept) begin
        pc      <= next_pc;
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboarded bench for pc_fetch: a behavioural memory checks fetch addresses
// and queues expected words; a monitor checks each newly valid instruction.
module tb_pc_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack, imem_err;
  logic [31:0] imem_rdata;
  logic [31:0] pc, instr;
  logic        instr_valid;
  logic        issue_ready = 1'b0;
  logic [31:0] next_pc = '0;
  logic [31:0] retired;
  logic        fault;

  logic        mem_ack = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_en = 1'b1, err_en = 1'b0, force_ack = 1'b0;
  logic [31:0] err_addr = '0;
  int          delay = 0, wcnt = 0;
  int          chk_cnt = 0, pass_cnt = 0, exp_ret = 0;
  logic [31:0] addr_q[$], data_q[$];
  logic [31:0] q_exp, mon_exp;
  logic        prev_valid = 1'b0;

  pc_fetch #(.RESET_PC(32'h10), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .issue_ready(issue_ready),
    .next_pc(next_pc), .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  // force_ack models a stray response outside any outstanding request
  assign imem_ack   = mem_ack | force_ack;
  assign imem_err   = mem_err;
  assign imem_rdata = force_ack ? 32'hDEAD_BEEF : mem_rdata;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h10) ? 32'h2000_0005 : (a ^ 32'hC0DE_0000);
  endfunction

  always @(negedge clk) begin
    if (rst || !imem_req || !mem_en) begin
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      if (rst || !imem_req) wcnt <= 0;
    end else if (wcnt == delay) begin
      mem_ack   <= 1'b1;
      mem_err   <= err_en && (imem_addr == err_addr);
      mem_rdata <= mem_data(imem_addr);
      wcnt      <= 0;
      chk_cnt++;
      if (addr_q.size() == 0) $display("FAIL fetch_addr: unexpected fetch at %h", imem_addr);
      else begin
        q_exp = addr_q.pop_front();
        if (imem_addr !== q_exp) $display("FAIL fetch_addr: got %h exp %h", imem_addr, q_exp);
        else pass_cnt++;
      end
      if (!(err_en && imem_addr == err_addr)) data_q.push_back(mem_data(imem_addr));
    end else begin
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      wcnt    <= wcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      chk_cnt++;
      if (data_q.size() == 0) $display("FAIL instr_data: valid instr %h with nothing expected", instr);
      else begin
        mon_exp = data_q.pop_front();
        if (instr !== mon_exp) $display("FAIL instr_data: got %h exp %h", instr, mon_exp);
        else pass_cnt++;
      end
    end
    prev_valid <= instr_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_en = 1'b1; err_en = 1'b0; delay = 0; exp_ret = 0;
    repeat (2) tick();
    chk_cnt++;
    if ({pc, instr, retired} !== {32'h10, 32'h0, 32'h0})
      $display("FAIL reset_regs: got pc=%h instr=%h ret=%h exp 10/0/0", pc, instr, retired);
    else pass_cnt++;
    chk_cnt++;
    if ({imem_req, instr_valid, fault} !== 3'b000)
      $display("FAIL reset_outs: got req/vld/fault=%b exp 000", {imem_req, instr_valid, fault});
    else pass_cnt++;
    addr_q.push_back(32'h10);
    rst = 1'b0;
    chk_cnt++;
    if (imem_req !== 1'b0) $display("FAIL idle_req: got %b exp 0", imem_req);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h10})
      $display("FAIL first_req: got req=%b addr=%h exp 1/10", imem_req, imem_addr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({instr_valid, instr} !== {1'b1, 32'h2000_0005})
      $display("FAIL first_valid: got vld=%b instr=%h exp 1/20000005", instr_valid, instr);
    else pass_cnt++;
    repeat (3) tick();
    chk_cnt++;
    if ({instr_valid, instr, pc, imem_req} !== {1'b1, 32'h2000_0005, 32'h10, 1'b0})
      $display("FAIL hold_valid: got vld=%b instr=%h pc=%h req=%b", instr_valid, instr, pc, imem_req);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      addr_q.push_back(32'(i));
      next_pc = 32'(i); issue_ready = 1'b1;
      tick(); exp_ret++;
      chk_cnt++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'(i), 1'b0})
        $display("FAIL stream_req: got req=%b addr=%h vld=%b exp 1/%h/0", imem_req, imem_addr, instr_valid, i);
      else pass_cnt++;
      chk_cnt++;
      if (retired !== 32'(exp_ret)) $display("FAIL stream_ret: got %0d exp %0d", retired, exp_ret);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({instr_valid, pc} !== {1'b1, 32'(i)})
        $display("FAIL stream_have: got vld=%b pc=%h exp 1/%h", instr_valid, pc, i);
      else pass_cnt++;
      issue_ready = 1'b0;
    end
    chk_cnt++;
    if (retired !== 32'd4) $display("FAIL stream_retired4: got %0d exp 4", retired);
    else pass_cnt++;
  endtask

  task automatic test_branch_stall();
    addr_q.push_back(32'h20);
    delay = 3; next_pc = 32'h20; issue_ready = 1'b1;
    tick(); exp_ret++; issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h20, 1'b0})
        $display("FAIL wait_req%0d: got req=%b addr=%h vld=%b", k, imem_req, imem_addr, instr_valid);
      else pass_cnt++;
      tick();
    end
    chk_cnt++;
    if ({instr_valid, instr} !== {1'b1, 32'hC0DE_0020})
      $display("FAIL delayed_valid: got vld=%b instr=%h exp 1/c0de0020", instr_valid, instr);
    else pass_cnt++;
    next_pc = 32'h99;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_cnt++;
      if ({instr_valid, pc, imem_req} !== {1'b1, 32'h20, 1'b0})
        $display("FAIL stall%0d: got vld=%b pc=%h req=%b", k, instr_valid, pc, imem_req);
      else pass_cnt++;
    end
    addr_q.push_back(32'h40);
    delay = 0; next_pc = 32'h40; issue_ready = 1'b1;
    tick(); exp_ret++; issue_ready = 1'b0;
    chk_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40})
      $display("FAIL branch_addr: got req=%b addr=%h exp 1/40", imem_req, imem_addr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({instr_valid, pc, retired} !== {1'b1, 32'h40, 32'(exp_ret)})
      $display("FAIL branch_have: got vld=%b pc=%h ret=%0d exp ret %0d", instr_valid, pc, retired, exp_ret);
    else pass_cnt++;
  endtask

  task automatic test_fault();
    addr_q.push_back(32'h7);
    err_en = 1'b1; err_addr = 32'h7; next_pc = 32'h7; issue_ready = 1'b1;
    tick(); exp_ret++;
    chk_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h7})
      $display("FAIL fault_req: got req=%b addr=%h exp 1/7", imem_req, imem_addr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({fault, pc, instr_valid, imem_req} !== {1'b1, 32'h7, 1'b0, 1'b0})
      $display("FAIL fault_enter: got fault=%b pc=%h vld=%b req=%b", fault, pc, instr_valid, imem_req);
    else pass_cnt++;
    chk_cnt++;
    if (instr !== 32'hC0DE_0040) $display("FAIL fault_instr: got %h exp c0de0040", instr);
    else pass_cnt++;
    force_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_cnt++;
      if ({fault, imem_req, instr_valid, pc} !== {1'b1, 1'b0, 1'b0, 32'h7})
        $display("FAIL fault_stuck%0d: got fault=%b req=%b vld=%b pc=%h", k, fault, imem_req, instr_valid, pc);
      else pass_cnt++;
    end
    force_ack = 1'b0; issue_ready = 1'b0; err_en = 1'b0;
    chk_cnt++;
    if (retired !== 32'(exp_ret)) $display("FAIL fault_ret: got %0d exp %0d", retired, exp_ret);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b1; mem_en = 1'b1;
    tick(); exp_ret = 0;
    addr_q.push_back(32'h10);
    rst = 1'b0;
    repeat (2) tick();
    mem_en = 1'b0; next_pc = 32'h33; issue_ready = 1'b1;
    tick(); exp_ret++; issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h33})
        $display("FAIL stuck_req%0d: got req=%b addr=%h exp 1/33", k, imem_req, imem_addr);
      else pass_cnt++;
      tick();
    end
    rst = 1'b1;
    #1;
    exp_ret = 0;
    chk_cnt++;
    if ({imem_req, pc, retired} !== {1'b0, 32'h10, 32'h0})
      $display("FAIL async_rst: got req=%b pc=%h ret=%0d exp 0/10/0", imem_req, pc, retired);
    else pass_cnt++;
    tick();
    rst = 1'b0; force_ack = 1'b1; mem_en = 1'b1;
    addr_q.push_back(32'h10);
    tick();
    force_ack = 1'b0;
    chk_cnt++;
    if ({imem_req, imem_addr, instr} !== {1'b1, 32'h10, 32'h0})
      $display("FAIL restart: got req=%b addr=%h instr=%h exp 1/10/0", imem_req, imem_addr, instr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({instr_valid, instr} !== {1'b1, 32'h2000_0005})
      $display("FAIL restart_valid: got vld=%b instr=%h", instr_valid, instr);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    addr_q.push_back(32'hFFFF_FFFF);
    next_pc = 32'hFFFF_FFFF; issue_ready = 1'b1;
    tick(); exp_ret++; issue_ready = 1'b0;
    chk_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFF})
      $display("FAIL wrap_top: got req=%b addr=%h exp 1/ffffffff", imem_req, imem_addr);
    else pass_cnt++;
    tick();
    addr_q.push_back(32'h0);
    next_pc = 32'h0; issue_ready = 1'b1;
    tick(); exp_ret++; issue_ready = 1'b0;
    chk_cnt++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_zero: got req=%b addr=%h exp 1/0", imem_req, imem_addr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({instr_valid, pc, retired} !== {1'b1, 32'h0, 32'(exp_ret)})
      $display("FAIL wrap_have: got vld=%b pc=%h ret=%0d exp ret %0d", instr_valid, pc, retired, exp_ret);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_branch_stall();
    test_fault();
    test_reset_mid_fetch();
    test_wrap();
    repeat (2) tick();
    chk_cnt++;
    if (addr_q.size() + data_q.size() != 0)
      $display("FAIL drain: got %0d addr / %0d data left exp 0", addr_q.size(), data_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
